// File: rtl/uart_rx_frame_if.sv
// Serial line input and received-byte output bundle for uart_rx_frame.
// The receiver takes the master side; a consumer of received bytes takes the slave side.
interface uart_rx_frame_if;
  logic       line_rx;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       frame_err;
  logic       busy;

  modport master (
    input  line_rx,
    output rx_data,
    output rx_valid,
    output frame_err,
    output busy
  );

  modport slave (
    output line_rx,
    input  rx_data,
    input  rx_valid,
    input  frame_err,
    input  busy
  );
endinterface

// File: rtl/uart_rx_frame.sv
// 8N1 UART receiver: 2-flop synchronizer, 3-sample majority vote per bit,
// one-cycle rx_valid on a good frame and frame_err on a low stop bit.
module uart_rx_frame #(
  parameter int CLKS_PER_BIT = 2500
) (
  input  logic           clk,
  input  logic           rst_n,
  uart_rx_frame_if.master bus
);
  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam int H  = CLKS_PER_BIT / 2;

  // Comparisons use the pre-edge count, so these land on the edges where
  // clk_cnt becomes H-1, H and H+1 respectively.
  localparam logic [CW-1:0] CAP_A    = CW'(H - 2);
  localparam logic [CW-1:0] CAP_B    = CW'(H - 1);
  localparam logic [CW-1:0] DECIDE   = CW'(H);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    WAIT_IDLE,
    IDLE,
    START,
    DATA,
    STOP
  } state_t;

  state_t        state_reg;
  logic [1:0]    sync_reg;
  logic [1:0]    prime_reg;
  logic [CW-1:0] clk_cnt_reg;
  logic [2:0]    bit_idx_reg;
  logic          cap_a_reg;
  logic          cap_b_reg;
  logic [7:0]    shift_reg;
  logic [7:0]    rx_data_reg;
  logic          rx_valid_reg;
  logic          frame_err_reg;
  logic          busy_reg;

  logic rx_s;
  logic maj;

  assign rx_s = sync_reg[1];
  assign maj  = (cap_a_reg & cap_b_reg) | (cap_a_reg & rx_s) | (cap_b_reg & rx_s);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg     <= WAIT_IDLE;
      sync_reg      <= 2'b11;
      prime_reg     <= 2'b00;
      clk_cnt_reg   <= '0;
      bit_idx_reg   <= 3'd0;
      cap_a_reg     <= 1'b1;
      cap_b_reg     <= 1'b1;
      shift_reg     <= 8'h00;
      rx_data_reg   <= 8'h00;
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;
      busy_reg      <= 1'b0;
    end else begin
      sync_reg      <= {sync_reg[0], bus.line_rx};
      // rx_s only reflects the real line two edges after reset release;
      // until then its reset value of 1 must not count as an idle line.
      prime_reg     <= {prime_reg[0], 1'b1};
      rx_valid_reg  <= 1'b0;
      frame_err_reg <= 1'b0;

      if (busy_reg) begin
        clk_cnt_reg <= (clk_cnt_reg == CNT_LAST) ? '0 : clk_cnt_reg + 1'b1;
        if (clk_cnt_reg == CAP_A) cap_a_reg <= rx_s;
        if (clk_cnt_reg == CAP_B) cap_b_reg <= rx_s;
      end

      case (state_reg)
        WAIT_IDLE: begin
          if (rx_s && prime_reg[1]) state_reg <= IDLE;
        end
        IDLE: begin
          if (!rx_s) begin
            state_reg   <= START;
            clk_cnt_reg <= '0;
            busy_reg    <= 1'b1;
          end
        end
        START: begin
          if (clk_cnt_reg == DECIDE && maj) begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end else if (clk_cnt_reg == CNT_LAST) begin
            state_reg   <= DATA;
            bit_idx_reg <= 3'd0;
          end
        end
        DATA: begin
          if (clk_cnt_reg == DECIDE) shift_reg <= {maj, shift_reg[7:1]};
          if (clk_cnt_reg == CNT_LAST) begin
            if (bit_idx_reg == 3'd7) state_reg <= STOP;
            else                     bit_idx_reg <= bit_idx_reg + 3'd1;
          end
        end
        STOP: begin
          // Leave at the stop-bit centre so an immediately following start edge is caught.
          if (clk_cnt_reg == DECIDE) begin
            busy_reg <= 1'b0;
            if (maj) begin
              rx_data_reg  <= shift_reg;
              rx_valid_reg <= 1'b1;
              state_reg    <= IDLE;
            end else begin
              frame_err_reg <= 1'b1;
              state_reg     <= WAIT_IDLE;
            end
          end
        end
        default: state_reg <= WAIT_IDLE;
      endcase
    end
  end

  assign bus.rx_data   = rx_data_reg;
  assign bus.rx_valid  = rx_valid_reg;
  assign bus.frame_err = frame_err_reg;
  assign bus.busy      = busy_reg;
endmodule

// File: tb/tb_uart_rx_frame.sv
// Directed bench for uart_rx_frame at 16 clocks per bit: single byte, back-to-back,
// false start, framing error, glitch immunity and reset in mid-frame.
module tb_uart_rx_frame;
  localparam int CPB = 16;
  localparam int H   = CPB / 2;

  logic clk;
  logic rst_n;
  uart_rx_frame_if bus ();

  uart_rx_frame #(.CLKS_PER_BIT(CPB)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Pulse monitor, sampled on the falling edge.
  int         n_valid = 0;
  int         n_err   = 0;
  int         n_both  = 0;
  int         busy_cnt = 0;
  logic [7:0] vdata [0:15];
  int         vcyc  [0:15];

  always @(negedge clk) begin
    if (bus.rx_valid) begin
      if (n_valid < 16) begin
        vdata[n_valid] <= bus.rx_data;
        vcyc[n_valid]  <= cyc;
      end
      n_valid <= n_valid + 1;
    end
    if (bus.frame_err) n_err <= n_err + 1;
    if (bus.rx_valid && bus.frame_err) n_both <= n_both + 1;
    if (bus.busy) busy_cnt <= busy_cnt + 1;
  end

  int n_checks = 0;
  int n_errors = 0;
  int e0;
  int first_e0;
  int v0, r0, b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_errors++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic drive_bit(input logic v, input int glitch_at);
    for (int t = 0; t < CPB; t++) begin
      bus.line_rx = (t == glitch_at) ? ~v : v;
      @(negedge clk);
    end
  endtask

  task automatic send_frame(input logic [7:0] b, input logic stop_v, input int gbit, input int gpos);
    e0 = cyc + 1;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 8; i++) drive_bit(b[i], (i == gbit) ? gpos : -1);
    drive_bit(stop_v, -1);
  endtask

  initial begin
    bus.line_rx = 1'b1;
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    check("reset_rx_data", bus.rx_data, 8'h00);
    check("reset_rx_valid", bus.rx_valid, 1'b0);
    check("reset_frame_err", bus.frame_err, 1'b0);
    check("reset_busy", bus.busy, 1'b0);
    rst_n = 1'b1;
    repeat (6) @(negedge clk);

    // Single byte, latency from E0 to the rx_valid cycle
    send_frame(8'h4A, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    check("single_count", n_valid, 1);
    check("single_data", vdata[0], 8'h4A);
    check("single_latency", vcyc[0] - e0, 155);
    check("single_no_err", n_err, 0);

    // Back-to-back frames, second start right after the first stop bit
    send_frame(8'h4A, 1'b1, -1, -1);
    first_e0 = e0;
    send_frame(8'h30, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    check("b2b_count", n_valid, 3);
    check("b2b_data0", vdata[1], 8'h4A);
    check("b2b_data1", vdata[2], 8'h30);
    check("b2b_gap", vcyc[2] - vcyc[1], 160);

    // False start: 4 low clocks
    v0 = n_valid; r0 = n_err; b0 = busy_cnt;
    bus.line_rx = 1'b0;
    repeat (4) @(negedge clk);
    bus.line_rx = 1'b1;
    repeat (2 * CPB) @(negedge clk);
    check("false_busy_pulsed", busy_cnt > b0, 1'b1);
    check("false_no_valid", n_valid - v0, 0);
    check("false_no_err", n_err - r0, 0);
    check("false_busy_low", bus.busy, 1'b0);

    // Framing error, then line held low for 48 clocks in total
    v0 = n_valid; r0 = n_err;
    send_frame(8'h55, 1'b0, -1, -1);
    bus.line_rx = 1'b0;
    repeat (32) @(negedge clk);
    check("ferr_count", n_err - r0, 1);
    check("ferr_no_valid", n_valid - v0, 0);
    check("ferr_data_kept", bus.rx_data, 8'h30);
    check("ferr_busy_low", bus.busy, 1'b0);
    bus.line_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'hA3, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    check("recover_count", n_valid - v0, 1);
    check("recover_data", bus.rx_data, 8'hA3);

    // Glitch at sample point H of data bit 2
    r0 = n_err;
    send_frame(8'h0F, 1'b1, 2, H);
    repeat (4) @(negedge clk);
    check("glitch_data", bus.rx_data, 8'h0F);
    check("glitch_no_err", n_err - r0, 0);

    // Reset during data bit 4 of 0xFF with the line low
    v0 = n_valid; r0 = n_err;
    bus.line_rx = 1'b0;
    drive_bit(1'b0, -1);
    for (int i = 0; i < 4; i++) drive_bit(1'b1, -1);
    bus.line_rx = 1'b0;
    repeat (8) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrst_rx_data", bus.rx_data, 8'h00);
    check("midrst_rx_valid", bus.rx_valid, 1'b0);
    check("midrst_frame_err", bus.frame_err, 1'b0);
    check("midrst_busy", bus.busy, 1'b0);
    repeat (5) @(negedge clk);
    rst_n = 1'b1;
    b0 = busy_cnt;
    repeat (48) @(negedge clk);
    check("postrst_no_busy", busy_cnt - b0, 0);
    check("postrst_no_valid", n_valid - v0, 0);
    check("postrst_no_err", n_err - r0, 0);
    bus.line_rx = 1'b1;
    repeat (20) @(negedge clk);
    send_frame(8'h81, 1'b1, -1, -1);
    repeat (4) @(negedge clk);
    check("postrst_data", bus.rx_data, 8'h81);

    check("no_overlap", n_both, 0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/uart_rx_frame.md
# uart_rx_frame

Asynchronous serial receiver for 8N1 frames: idle high, one start bit (0), eight data bits LSB first, one stop bit (1). It is the downstream counterpart of the team's UART transmitter, which holds each bit for 2500 clocks. It recovers each byte from `line_rx` and presents it on `rx_data` with a one-cycle `rx_valid` strobe. It also flags frames whose stop bit is low.

## Interface
- `CLKS_PER_BIT`, default 2500: clocks per bit period.
  - Must be at least 8.
  - Counter width is ceil(log2(CLKS_PER_BIT)).
  - `H` = `CLKS_PER_BIT`/2, integer division.
- `clk`  in  1  system clock.
- `rst_n`  in  1  reset, asynchronous, active-low.
- `line_rx`  in  1  serial line, asynchronous to `clk`.
- `rx_data`  out  8  last good byte. Reset 0x00. Held until the next good frame.
- `rx_valid`  out  1  one-cycle pulse when `rx_data` has just been updated. Reset 0.
- `frame_err`  out  1  one-cycle pulse on a bad stop bit. Reset 0.
- `busy`  out  1  high while in START, DATA or STOP. Reset 0.

## Operation
- **Synchronizer:** two flops on `line_rx`, both reset to 1. The output is `rx_s`. The FSM uses only `rx_s`.
- **Counters:**
  - `clk_cnt` counts 0..CLKS_PER_BIT-1 within each bit, then wraps to 0.
  - `bit_idx` (3 bits) counts data bits.
- **Sampling:**
  - In each bit, `rx_s` is captured on the edges where `clk_cnt` = H-1 and H.
  - At `clk_cnt` = H+1 the bit value is the majority of those two captures and the current `rx_s`.
- **FSM states:** WAIT_IDLE (reset state), IDLE, START, DATA, STOP.
  - **WAIT_IDLE:** when `rx_s`=1, go to IDLE. This blocks frames that begin mid-byte after reset or after a framing error.
  - **IDLE:** when `rx_s`=0, go to START with `clk_cnt`=0.
  - **START:**
    - At the majority point, a majority of 1 is a false start: go to IDLE with no pulse.
    - Otherwise, at `clk_cnt`=CLKS_PER_BIT-1 go to DATA with `bit_idx`=0.
  - **DATA:**
    - At each majority point, shift the bit value into the shift register from the MSB end, so the result is LSB first.
    - At `clk_cnt`=CLKS_PER_BIT-1, if `bit_idx`=7 go to STOP; otherwise increment `bit_idx`.
  - **STOP:** decided at the majority point.
    - Majority 1: load `rx_data` from the shift register, pulse `rx_valid`, go to IDLE immediately. The rest of the stop bit is not waited out, so a start bit that follows the stop bit directly is caught.
    - Majority 0: pulse `frame_err`, leave `rx_data` unchanged, go to WAIT_IDLE.
- `rx_valid` and `frame_err` are never high in the same cycle. Each is high for exactly one clock per frame.
- **Reset mid-frame:** all outputs return to their reset values at once and no pulse is emitted. After release, no frame is accepted until `rx_s` has been 1 for at least one cycle.

## Timing
- **Start detection:** let E0 be the first clk edge at which the first synchronizer flop samples `line_rx`=0.
  - `rx_s`=0 after E1.
  - The FSM enters START at E2, with `clk_cnt`=0 in the following cycle.
- **Decision edges:** bit n (start bit = 0, stop bit = 9) is decided at edge E2 + n·CLKS_PER_BIT + H + 1.
- **Output latency:** `rx_valid` / `frame_err` is high in the single cycle after edge E0 + 9·CLKS_PER_BIT + H + 3.
  - For CLKS_PER_BIT=2500 this is 23753 edges after E0.
  - For CLKS_PER_BIT=16 it is 155.
- `rx_data` changes on the same edge that raises `rx_valid`.
- `busy` rises one cycle after `rx_s` first reads 0 and falls on the stop-bit decision edge.
- **Tolerated rate error:** about ±4% total between transmitter and receiver. Each bit is sampled at its centre and the receiver re-aligns on every start edge.

## Test plan
- **Single byte** (CLKS_PER_BIT=16): send 0x4A at 16 clk/bit -> `rx_data`=0x4A with a one-cycle `rx_valid` 155 edges after E0; `frame_err` stays 0.
- **Back-to-back frames:** send 0x4A then 0x30, with the second start bit directly after the first stop bit -> two `rx_valid` pulses, 160 clocks apart, carrying 0x4A then 0x30.
- **False start:** drive `line_rx` low for 4 clocks, then high -> `busy` pulses briefly; no `rx_valid`, no `frame_err`; FSM back in IDLE.
- **Framing error:**
  - Send 0x55 with a low stop bit and hold the line low for 48 clocks -> one `frame_err` pulse; `rx_data` keeps its prior value; no further activity while the line stays low.
  - Then raise the line and send 0xA3 -> `rx_data`=0xA3 with `rx_valid`.
- **Glitch immunity:** send 0x0F with a 1-clock inversion at sample point H of data bit 2 -> `rx_data`=0x0F.
- **Reset mid-frame:** assert `rst_n` during data bit 4 of 0xFF while the line is low -> all outputs 0 and no pulses.
  - After release with the line still low: no activity.
  - After the line idles high and 0x81 is sent: `rx_data`=0x81.
